// File: rtl/serv_mem_arbiter_if.sv
// rtl/serv_mem_arbiter_if.sv - CPU ibus/dbus and memory-side Wishbone signals of the arbiter
interface serv_mem_arbiter_if;
    // instruction fetch port
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    // data load/store port
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    // memory-side Wishbone classic request and response
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    // arbiter view
    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_dbus_rdt, o_dbus_ack,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack
    );

    // environment view: CPU masters and memory
    modport master (
        output i_ibus_adr, i_ibus_cyc,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack
    );
endinterface

// File: rtl/serv_mem_arbiter.sv
// rtl/serv_mem_arbiter.sv - two-master (ibus/dbus) to single Wishbone memory arbiter with timeout
module serv_mem_arbiter #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERR_RDT = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                i_rst_n,
    serv_mem_arbiter_if.slave   bus,
    output logic                o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        RESP = 2'd3
    } state_t;

    // last count value before a silent memory is abandoned
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        busy;
    logic        to_hit;
    logic        timed_out;
    logic        gnt_dbus;
    logic [31:0] rsp_rdt;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;

    assign busy   = (state == IBUS) || (state == DBUS);
    assign to_hit = busy && !bus.i_wb_ack && (cnt == CNT_LAST);

    // state register; reset always returns to IDLE, even mid-transfer
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: dbus has fixed priority, RESP is a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_dbus_cyc) begin
                    state_nxt = DBUS;
                end else if (bus.i_ibus_cyc) begin
                    state_nxt = IBUS;
                end
            end
            IBUS, DBUS: begin
                if (bus.i_wb_ack || to_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wait counter and timeout flag; an ack in the final count cycle wins over timeout
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            if (!busy) begin
                cnt <= '0;
            end else if (!bus.i_wb_ack) begin
                cnt <= cnt + 16'd1;
            end
            if (busy && bus.i_wb_ack) begin
                timed_out <= 1'b0;
            end else if (to_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

    // request fields latched at grant, response data latched at completion; not reset
    always_ff @(posedge clk) begin
        if (state == IDLE && state_nxt == DBUS) begin
            gnt_dbus <= 1'b1;
            wb_adr   <= bus.i_dbus_adr;
            wb_dat   <= bus.i_dbus_dat;
            wb_sel   <= bus.i_dbus_sel;
            wb_we    <= bus.i_dbus_we;
        end else if (state == IDLE && state_nxt == IBUS) begin
            gnt_dbus <= 1'b0;
            wb_adr   <= bus.i_ibus_adr;
            wb_dat   <= 32'h0000_0000;
            wb_sel   <= 4'hF;
            wb_we    <= 1'b0;
        end
        if (busy && bus.i_wb_ack) begin
            rsp_rdt <= bus.i_wb_rdt;
        end else if (to_hit) begin
            rsp_rdt <= ERR_RDT;
        end
    end

    // outputs decoded from state; only the acks are qualified by the granted master
    always_comb begin
        bus.o_wb_cyc   = busy;
        bus.o_ibus_ack = (state == RESP) && !gnt_dbus;
        bus.o_dbus_ack = (state == RESP) && gnt_dbus;
        o_timeout      = (state == RESP) && timed_out;
    end

    assign bus.o_wb_adr   = wb_adr;
    assign bus.o_wb_dat   = wb_dat;
    assign bus.o_wb_sel   = wb_sel;
    assign bus.o_wb_we    = wb_we;
    assign bus.o_ibus_rdt = rsp_rdt;
    assign bus.o_dbus_rdt = rsp_rdt;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// tb/tb_serv_mem_arbiter.sv - randomized self-checking bench for serv_mem_arbiter
module tb_serv_mem_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hBAD0_0BAD;

    logic clk = 1'b0;
    logic i_rst_n;
    logic o_timeout;

    int checks   = 0;
    int failures = 0;

    serv_mem_arbiter_if bus ();

    serv_mem_arbiter #(
        .TIMEOUT (TMO),
        .ERR_RDT (ERR)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .bus       (bus),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One granted transfer. w = memory wait cycles before ack (-1: memory never acks).
    // first_exp = negedge index (from call) at which o_wb_cyc should first be seen.
    task automatic do_txn(input bit is_d, input int first_exp, input int w,
                          input logic [31:0] rdt, input bit drop_mid);
        int          cyc_cnt;
        bit          done;
        int          exp_cyc;
        bit          exp_to;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [3:0]  exp_sel;
        logic        exp_we;
        cyc_cnt = 0;
        done    = 1'b0;
        exp_adr = is_d ? bus.i_dbus_adr : bus.i_ibus_adr;
        exp_dat = is_d ? bus.i_dbus_dat : 32'h0;
        exp_sel = is_d ? bus.i_dbus_sel : 4'hF;
        exp_we  = is_d ? bus.i_dbus_we  : 1'b0;
        exp_to  = !(w >= 0 && w + 1 <= TMO);
        exp_cyc = exp_to ? TMO : w + 1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (bus.o_wb_cyc) begin
                if (cyc_cnt == 0) begin
                    check("grant_latency", t, first_exp);
                    check("wb_we", {31'b0, bus.o_wb_we}, {31'b0, exp_we});
                    check("wb_sel", {28'b0, bus.o_wb_sel}, {28'b0, exp_sel});
                    check("wb_dat", bus.o_wb_dat, exp_dat);
                end
                check("wb_adr", bus.o_wb_adr, exp_adr);
                check("no_ack_in_cyc", {29'b0, bus.o_ibus_ack, bus.o_dbus_ack, o_timeout}, 32'h0);
                cyc_cnt++;
                if (drop_mid && cyc_cnt == 1) begin
                    if (is_d) bus.i_dbus_cyc = 1'b0;
                    else      bus.i_ibus_cyc = 1'b0;
                end
                bus.i_wb_ack = (w >= 0 && cyc_cnt == w + 1);
                bus.i_wb_rdt = bus.i_wb_ack ? rdt : $urandom;
            end else begin
                if (bus.o_ibus_ack || bus.o_dbus_ack) begin
                    check("ack_owner", {30'b0, bus.o_ibus_ack, bus.o_dbus_ack},
                          is_d ? 32'h1 : 32'h2);
                    check("cyc_cycles", cyc_cnt, exp_cyc);
                    check("rsp_rdt", is_d ? bus.o_dbus_rdt : bus.o_ibus_rdt, exp_to ? ERR : rdt);
                    check("rdt_shared", bus.o_ibus_rdt, bus.o_dbus_rdt);
                    check("timeout_pulse", {31'b0, o_timeout}, {31'b0, exp_to});
                    done = 1'b1;
                    if (is_d) bus.i_dbus_cyc = 1'b0;
                    else      bus.i_ibus_cyc = 1'b0;
                end else begin
                    check("idle_no_timeout", {31'b0, o_timeout}, 32'h0);
                end
                // stray acks while not in a transfer must be ignored
                bus.i_wb_ack = 1'($urandom_range(0, 1));
                bus.i_wb_rdt = $urandom;
            end
        end
        if (!done) check("txn_completed", 32'h0, 32'h1);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {28'b0, bus.o_wb_cyc, bus.o_ibus_ack, bus.o_dbus_ack, o_timeout}, 32'h0);
    endtask

    initial begin
        int mode;
        int gap;
        int w1;
        int w2;
        bit drop;
        i_rst_n        = 1'b0;
        bus.i_ibus_adr = '0;
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_adr = '0;
        bus.i_dbus_dat = '0;
        bus.i_dbus_sel = '0;
        bus.i_dbus_we  = 1'b0;
        bus.i_dbus_cyc = 1'b0;
        bus.i_wb_rdt   = '0;
        bus.i_wb_ack   = 1'b0;

        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        i_rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle_after_reset");

        // single fetch, zero-wait memory
        bus.i_ibus_adr = 32'h0000_0100;
        bus.i_ibus_cyc = 1'b1;
        do_txn(1'b0, 0, 0, 32'h0000_0013, 1'b0);
        @(negedge clk);

        // simultaneous requests: dbus store first, ibus granted two cycles after its ack
        bus.i_dbus_adr = 32'h0000_2000;
        bus.i_dbus_dat = 32'hDEAD_BEEF;
        bus.i_dbus_sel = 4'h3;
        bus.i_dbus_we  = 1'b1;
        bus.i_dbus_cyc = 1'b1;
        bus.i_ibus_adr = 32'h0000_0104;
        bus.i_ibus_cyc = 1'b1;
        do_txn(1'b1, 0, 0, 32'h1111_2222, 1'b0);
        do_txn(1'b0, 1, 0, 32'h3333_4444, 1'b0);
        @(negedge clk);

        // load to a silent memory times out; then ack exactly on the final count
        bus.i_dbus_adr = 32'h0000_3000;
        bus.i_dbus_we  = 1'b0;
        bus.i_dbus_sel = 4'hF;
        bus.i_dbus_cyc = 1'b1;
        do_txn(1'b1, 0, -1, 32'h5555_6666, 1'b0);
        @(negedge clk);
        bus.i_dbus_cyc = 1'b1;
        do_txn(1'b1, 0, TMO - 1, 32'h7777_8888, 1'b0);
        @(negedge clk);

        // reset pulse during a dbus wait state, request held and re-granted
        bus.i_wb_ack   = 1'b0;
        bus.i_dbus_adr = 32'h0000_4000;
        bus.i_dbus_cyc = 1'b1;
        @(negedge clk);
        check("rst_pre_cyc", {31'b0, bus.o_wb_cyc}, 32'h1);
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid_transfer");
        i_rst_n = 1'b1;
        do_txn(1'b1, 0, 1, 32'h9999_AAAA, 1'b0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            mode = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            w1   = $urandom_range(0, 7) - 1;
            w2   = $urandom_range(0, 7) - 1;
            drop = (mode != 2) && ($urandom_range(0, 5) == 0);
            repeat (gap) @(negedge clk);
            bus.i_ibus_adr = $urandom & 32'hFFFF_FFFC;
            bus.i_dbus_adr = $urandom;
            bus.i_dbus_dat = $urandom;
            bus.i_dbus_sel = 4'($urandom_range(0, 15));
            bus.i_dbus_we  = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                bus.i_ibus_cyc = 1'b1;
                do_txn(1'b0, (gap == 0) ? 1 : 0, w1, $urandom, drop);
            end else if (mode == 1) begin
                bus.i_dbus_cyc = 1'b1;
                do_txn(1'b1, (gap == 0) ? 1 : 0, w1, $urandom, drop);
            end else begin
                bus.i_ibus_cyc = 1'b1;
                bus.i_dbus_cyc = 1'b1;
                do_txn(1'b1, (gap == 0) ? 1 : 0, w1, $urandom, 1'b0);
                do_txn(1'b0, 1, w2, $urandom, 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        check_quiet("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_mem_arbiter.md
SERV_MEM_ARBITER -- requirements
Module: serv_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles a memory transfer waits for i_wb_ack before forced termination (range 2..65535).
REQ-002 SHALL have parameter ERR_RDT, default 32'h0000_0000: read data returned on timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_ibus_adr  input  32  instruction fetch address from CPU.
REQ-006 i_ibus_cyc  input  1  instruction fetch request, held until acked.
REQ-007 o_ibus_rdt  output  32  fetched instruction word.
REQ-008 o_ibus_ack  output  1  one-cycle fetch completion pulse.
REQ-009 i_dbus_adr, i_dbus_dat  input  32 each  data address / write data.
REQ-010 i_dbus_sel  input  4  byte enables; i_dbus_we  input  1  write strobe; i_dbus_cyc  input  1  data request, held until acked.
REQ-011 o_dbus_rdt  output  32  load data; o_dbus_ack  output  1  one-cycle data completion pulse.
REQ-012 o_wb_adr, o_wb_dat  output  32 each; o_wb_sel  output  4; o_wb_we  output  1; o_wb_cyc  output  1  memory-side Wishbone classic request (stb tied equal to cyc externally).
REQ-013 i_wb_rdt  input  32; i_wb_ack  input  1  memory response.
REQ-014 o_timeout  output  1  one-cycle pulse when a transfer is terminated by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, IBUS, DBUS, RESP.
REQ-016 IDLE: if i_dbus_cyc -> DBUS; else if i_ibus_cyc -> IBUS; else stay; dbus has fixed priority when both asserted in same cycle.
REQ-017 On IDLE->IBUS/DBUS, SHALL register granted master's adr (and dat/sel/we for dbus; ibus grant forces we=0, sel=4'hF, dat=0) into o_wb_*; fields held stable until leaving state.
REQ-018 o_wb_cyc SHALL be 1 exactly while in IBUS or DBUS; first asserted the cycle after the request is first seen in IDLE.
REQ-019 In IBUS/DBUS, cycle with i_wb_ack=1: SHALL capture i_wb_rdt into response register, go to RESP, drop o_wb_cyc next cycle.
REQ-020 Timeout counter SHALL clear on entering IBUS/DBUS, increment each cycle without ack; when it reaches TIMEOUT-1 with no ack, SHALL load ERR_RDT into response register, pulse o_timeout next cycle, go to RESP.
REQ-021 Ack and timeout in same cycle: ack wins, no o_timeout.
REQ-022 RESP: assert o_ibus_ack or o_dbus_ack (granted master only) for exactly one cycle with o_*_rdt = response register; then unconditionally IDLE.
REQ-023 RESP lasts one cycle, so master dropping cyc after ack is never re-granted for the same request.
REQ-024 i_wb_ack outside IBUS/DBUS (late ack after timeout) SHALL be ignored: no state, rdt or ack change.
REQ-025 o_ibus_rdt/o_dbus_rdt SHALL both show the response register; only acks are qualified.
REQ-026 Latency: request seen cycle 0, o_wb_cyc cycles 1..k (ack in k), master ack cycle k+1; zero-wait memory gives 2-cycle request-to-ack.
REQ-027 Master deasserting cyc mid-transfer (illegal) SHALL NOT abort memory transfer; completion ack still issued.

Reset
REQ-028 i_rst_n=0 at a rising edge SHALL force IDLE, o_wb_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_timeout=0, counter=0 from next cycle, regardless of state, including mid-transfer.
REQ-029 Response register, o_wb_adr/dat/sel/we SHALL NOT be reset; values undefined until first grant/response.
REQ-030 First grant SHALL occur no earlier than the cycle after i_rst_n returns to 1.

Verification
REQ-031 ibus only, adr 0x100, memory acks 1st cycle with rdt 0x00000013 -> o_wb_cyc cycle 1, we=0, sel=F, o_ibus_ack cycle 2 with rdt 0x00000013, o_dbus_ack stays 0.
REQ-032 ibus and dbus (store adr 0x2000, dat 0xDEADBEEF, sel 0x3) raised same cycle -> dbus served first, o_wb_we=1, sel=3; after o_dbus_ack, ibus granted 2 cycles later (RESP, IDLE).
REQ-033 dbus load, memory never acks, TIMEOUT=4 -> o_wb_cyc high 4 cycles, o_timeout and o_dbus_ack pulse together with rdt=ERR_RDT; later i_wb_ack ignored.
REQ-034 Ack and timeout coincide on final count -> ack data returned, o_timeout=0.
REQ-035 i_rst_n low for one cycle during DBUS wait-state -> next cycle o_wb_cyc=0, no ack; held request re-granted after reset released.
REQ-036 Back-to-back ibus fetches, 3-wait memory -> each o_ibus_ack exactly one cycle, one memory transfer per ack, none duplicated.
